// File: rtl/disp_pkg.sv
// ----------------------------------------------------------------------------
// disp_pkg
// Shared types and constants for the multiplexed 4-digit display scanner.
//   state_e      : sequencer phase (BLANK between digits, SHOW while lit)
//   AN_DIGn      : active-low anode pattern for digit n (digit 0 = leftmost)
//   AN_OFF       : all anodes disabled
//   an_pattern() : digit index -> anode pattern
//   snap_nibble(): digit index -> hex nibble of a 16-bit display word
// ----------------------------------------------------------------------------
package disp_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_e;

    localparam logic [3:0] AN_DIG0 = 4'b0111;
    localparam logic [3:0] AN_DIG1 = 4'b1011;
    localparam logic [3:0] AN_DIG2 = 4'b1101;
    localparam logic [3:0] AN_DIG3 = 4'b1110;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    function automatic logic [3:0] an_pattern(input logic [1:0] digit);
        logic [3:0] pat;
        case (digit)
            2'd0:    pat = AN_DIG0;
            2'd1:    pat = AN_DIG1;
            2'd2:    pat = AN_DIG2;
            default: pat = AN_DIG3;
        endcase
        return pat;
    endfunction

    // Digit 0 is the most significant nibble.
    function automatic logic [3:0] snap_nibble(input logic [15:0] word,
                                               input logic [1:0]  digit);
        logic [3:0] nib;
        case (digit)
            2'd0:    nib = word[15:12];
            2'd1:    nib = word[11:8];
            2'd2:    nib = word[7:4];
            default: nib = word[3:0];
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// ----------------------------------------------------------------------------
// seg_scan_ctrl_if
// Bundle of the display scanner's data-side signals.
//   sw          : raw page-select switches {SW1,SW2} (asynchronous)
//   page0..3    : 16-bit display words, one per page
//   an          : active-low digit enables (one-cold or all high)
//   nibble      : hex value for the external segment decoder
//   frame_start : one-clock pulse on the first lit cycle of digit 0
//   page_cur    : page currently being displayed
// master = the side that owns switches/pages, slave = the scanner.
// ----------------------------------------------------------------------------
interface seg_scan_ctrl_if;

    logic [1:0]  sw;
    logic [15:0] page0;
    logic [15:0] page1;
    logic [15:0] page2;
    logic [15:0] page3;
    logic [3:0]  an;
    logic [3:0]  nibble;
    logic        frame_start;
    logic [1:0]  page_cur;

    modport master (
        output sw, page0, page1, page2, page3,
        input  an, nibble, frame_start, page_cur
    );

    modport slave (
        input  sw, page0, page1, page2, page3,
        output an, nibble, frame_start, page_cur
    );

endinterface

// File: rtl/sw_debounce.sv
// ----------------------------------------------------------------------------
// sw_debounce
// Two-flop synchronizer followed by a debouncer for a WIDTH-bit switch bank.
// The output changes only after the synchronized value has differed from it
// and held one constant value for DEB_CYCLES consecutive clocks.
//   clk   : system clock
//   reset : synchronous, active-high
//   sw_i  : raw asynchronous switch inputs
//   sw_o  : debounced, synchronous switch value
// ----------------------------------------------------------------------------
module sw_debounce #(
    parameter int DEB_CYCLES = 1000000,
    parameter int WIDTH      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_i,
    output logic [WIDTH-1:0] sw_o
);

    // Wide enough to hold DEB_CYCLES itself (the accept threshold).
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    run_len;

    always_comb begin
        cand_d   = cand_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        // Length of the current run including this clock; any change of
        // value (or a fresh start) restarts the run at 1.
        run_len  = (cnt_q != '0 && sync2_q == cand_q) ? cnt_q + CW'(1) : CW'(1);
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (run_len >= CW'(DEB_CYCLES)) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cand_d = sync2_q;
            cnt_d  = run_len;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sw_i;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sw_o = stable_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scanner for a 4-digit common-anode hex display.
// Each digit is lit for PRESCALE clocks, then all anodes are off for
// BLANK_CYCLES clocks before the next digit. At the start of every frame
// (BLANK of digit 3 -> SHOW of digit 0) the debounced page select and the
// selected 16-bit page word are captured, so the whole frame is tear-free.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : seg_scan_ctrl_if.slave (sw, page0..3 in; an, nibble,
//           frame_start, page_cur out)
// ----------------------------------------------------------------------------
module seg_scan_ctrl
    import disp_pkg::*;
#(
    parameter int PRESCALE     = 65536,
    parameter int BLANK_CYCLES = 256,
    parameter int DEB_CYCLES   = 1000000
) (
    input  logic           clk,
    input  logic           reset,
    seg_scan_ctrl_if.slave bus
);

    localparam int PH_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PH_W-1:0] SHOW_LAST  = PH_W'(PRESCALE - 1);
    localparam logic [PH_W-1:0] BLANK_LAST = PH_W'(BLANK_CYCLES - 1);

    state_e      state_q, state_d;
    logic [1:0]  digit_q, digit_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [15:0] snap_q, snap_d;
    logic [1:0]  page_cur_q, page_cur_d;

    logic [1:0]  deb_sw;
    logic [15:0] page_sel;

    sw_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .WIDTH      (2)
    ) u_sw_debounce (
        .clk   (clk),
        .reset (reset),
        .sw_i  (bus.sw),
        .sw_o  (deb_sw)
    );

    // Page word addressed by the debounced switches; only sampled at the
    // frame boundary.
    always_comb begin
        case (deb_sw)
            2'd0:    page_sel = bus.page0;
            2'd1:    page_sel = bus.page1;
            2'd2:    page_sel = bus.page2;
            default: page_sel = bus.page3;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        digit_d    = digit_q;
        phase_d    = phase_q + PH_W'(1);
        snap_d     = snap_q;
        page_cur_d = page_cur_q;
        case (state_q)
            SHOW: begin
                if (phase_q == SHOW_LAST) begin
                    state_d = BLANK;
                    phase_d = '0;
                end
            end
            BLANK: begin
                if (phase_q == BLANK_LAST) begin
                    state_d = SHOW;
                    phase_d = '0;
                    digit_d = digit_q + 2'd1;
                    // Frame boundary: capture page and word together.
                    if (digit_q == 2'd3) begin
                        page_cur_d = deb_sw;
                        snap_d     = page_sel;
                    end
                end
            end
            default: begin
                state_d = BLANK;
                phase_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BLANK;
            digit_q    <= 2'd3;
            phase_q    <= '0;
            snap_q     <= '0;
            page_cur_q <= '0;
        end else begin
            state_q    <= state_d;
            digit_q    <= digit_d;
            phase_q    <= phase_d;
            snap_q     <= snap_d;
            page_cur_q <= page_cur_d;
        end
    end

    // Outputs decode registered state only. During BLANK the digit index
    // still names the digit just shown, so nibble naturally holds its value.
    assign bus.an          = (state_q == SHOW) ? an_pattern(digit_q) : AN_OFF;
    assign bus.nibble      = snap_nibble(snap_q, digit_q);
    assign bus.frame_start = (state_q == SHOW) && (digit_q == 2'd0) && (phase_q == '0);
    assign bus.page_cur    = page_cur_q;

endmodule
